// File: rtl/l1_mem_arbiter.sv
// Two-port L1 (I$ = port 0, D$ = port 1) arbiter for a single external memory port.
// One registered transaction at a time, round-robin fairness, ownership lock and timeout.
module l1_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic                  p0_lock,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  output logic                  p0_ready,
  output logic                  p0_err,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic                  p1_lock,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  p1_ready,
  output logic                  p1_err,
  output logic                  mem_request,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_response_data,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  owner
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  localparam bit          TimeoutEn  = (TIMEOUT != 0);
  localparam int unsigned TimerWidth = TimeoutEn ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TimeoutEn ? TIMEOUT - 1 : 0);

  state_e                r_state, w_state_next;
  logic                  r_owner, r_rr, r_lock_vld, r_lock_port, r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_p0_rdata, r_p1_rdata;
  logic                  r_p0_ready, r_p0_err, r_p1_ready, r_p1_err;
  logic [TimerWidth-1:0] r_timer;
  logic                  w_elig0, w_elig1, w_grant, w_grant_port, w_done, w_timeout;

  // A port still showing its completion pulse is not eligible, so a held req is not re-granted.
  assign w_elig0 = p0_req & ~r_p0_ready & ~r_p0_err;
  assign w_elig1 = p1_req & ~r_p1_ready & ~r_p1_err;

  always_comb begin
    w_grant      = 1'b0;
    w_grant_port = 1'b0;
    if (r_state == StIdle) begin
      if (r_lock_vld) begin
        w_grant      = r_lock_port ? w_elig1 : w_elig0;
        w_grant_port = r_lock_port;
      end else if (w_elig0 && w_elig1) begin
        w_grant      = 1'b1;
        w_grant_port = r_rr;
      end else if (w_elig0 || w_elig1) begin
        w_grant      = 1'b1;
        w_grant_port = w_elig1;
      end
    end
  end

  // mem_ready takes priority over an expiring timer on the same edge.
  assign w_done    = (r_state == StBusy) && mem_ready;
  assign w_timeout = TimeoutEn && (r_state == StBusy) && !mem_ready && (r_timer == TimerLast);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (w_grant) w_state_next = StBusy;
      StBusy: if (w_done || w_timeout) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    busy        = (r_state == StBusy);
    mem_request = (r_state == StBusy);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner     <= 1'b0;
      r_rr        <= 1'b0;
      r_lock_vld  <= 1'b0;
      r_lock_port <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_p0_rdata  <= '0;
      r_p1_rdata  <= '0;
      r_p0_ready  <= 1'b0;
      r_p0_err    <= 1'b0;
      r_p1_ready  <= 1'b0;
      r_p1_err    <= 1'b0;
      r_timer     <= '0;
    end else begin
      r_p0_ready <= 1'b0;
      r_p0_err   <= 1'b0;
      r_p1_ready <= 1'b0;
      r_p1_err   <= 1'b0;
      if (w_grant) begin
        r_addr  <= w_grant_port ? p1_addr : p0_addr;
        r_wdata <= w_grant_port ? p1_wdata : p0_wdata;
        r_we    <= w_grant_port ? p1_we : p0_we;
        r_owner <= w_grant_port;
        r_rr    <= ~w_grant_port;
        r_timer <= '0;
      end else if (w_done) begin
        if (r_owner) begin
          r_p1_ready <= 1'b1;
          if (!r_we) r_p1_rdata <= mem_response_data;
        end else begin
          r_p0_ready <= 1'b1;
          if (!r_we) r_p0_rdata <= mem_response_data;
        end
        r_lock_vld  <= r_owner ? p1_lock : p0_lock;
        r_lock_port <= r_owner;
      end else if (w_timeout) begin
        r_p0_err   <= ~r_owner;
        r_p1_err   <= r_owner;
        r_lock_vld <= 1'b0;
      end else if (TimeoutEn && (r_state == StBusy)) begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

  assign p0_rdata         = r_p0_rdata;
  assign p0_ready         = r_p0_ready;
  assign p0_err           = r_p0_err;
  assign p1_rdata         = r_p1_rdata;
  assign p1_ready         = r_p1_ready;
  assign p1_err           = r_p1_err;
  assign mem_write_enable = r_we;
  assign mem_address      = r_addr;
  assign mem_write_data   = r_wdata;
  assign owner            = r_owner;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Bench for l1_mem_arbiter: behavioural memory, grant/completion scoreboards,
// a transaction table and hand-written fairness, lock and reset sequences.
module tb_l1_mem_arbiter;
  localparam int unsigned TO = 8;

  logic        clk, reset;
  logic        p0_req, p0_we, p0_lock, p0_ready, p0_err;
  logic        p1_req, p1_we, p1_lock, p1_ready, p1_err;
  logic [31:0] p0_addr, p0_wdata, p0_rdata, p1_addr, p1_wdata, p1_rdata;
  logic        mem_request, mem_write_enable, mem_ready, busy, owner;
  logic [31:0] mem_address, mem_write_data, mem_response_data;

  l1_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_rdata(p0_rdata), .p0_ready(p0_ready), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_rdata(p1_rdata), .p1_ready(p1_ready), .p1_err(p1_err),
    .mem_request(mem_request), .mem_write_enable(mem_write_enable),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_response_data(mem_response_data), .mem_ready(mem_ready),
    .busy(busy), .owner(owner)
  );

  typedef struct {bit port; bit we; logic [31:0] addr; logic [31:0] wdata; int gap;} grant_t;
  typedef struct {bit port; bit err; logic [31:0] rdata; int lat;} done_t;
  typedef struct {
    bit port; bit we; logic [31:0] addr; logic [31:0] wdata; int delay; logic [31:0] rdata; bit err;
  } vec_t;

  int          n_checks = 0, n_errors = 0, cyc = 0;
  int          mem_delay = 1, resp_cnt = 0;
  bit          force_ready = 0;
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] last_rd [2];
  grant_t      grant_q[$];
  done_t       done_q[$];
  vec_t        vecs [9];
  bit          mon_prev_req = 0, mon_is1;
  int          grant_cyc = 0, last_done_cyc = 0;
  logic [31:0] cap_addr, cap_wdata;
  grant_t      mon_g;
  done_t       mon_d;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] mem_default(logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  task automatic expect_txn(bit port, bit we, logic [31:0] addr, logic [31:0] wdata,
                            logic [31:0] rdata, bit err, int lat, int gap);
    grant_t g;
    done_t  d;
    g.port = port; g.we = we; g.addr = addr; g.wdata = wdata; g.gap = gap;
    d.port = port; d.err = err; d.lat = lat;
    d.rdata = (we || err) ? last_rd[port] : rdata;
    if (!we && !err) last_rd[port] = rdata;
    grant_q.push_back(g);
    done_q.push_back(d);
  endtask

  // Leaves req asserted on return so a caller can chain a held request.
  task automatic drive(bit port, bit we, bit lock, logic [31:0] addr, logic [31:0] wdata);
    int i;
    if (port) begin
      p1_we = we; p1_lock = lock; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
    end else begin
      p0_we = we; p0_lock = lock; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
    end
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (port ? (p1_ready | p1_err) : (p0_ready | p0_err)) break;
    end
    if (i == 100) chk("completion_wait", 32'(port ? p1_req : p0_req), 32'd0);
  endtask

  task automatic release_port(bit port);
    if (port) begin p1_req = 1'b0; p1_lock = 1'b0; end
    else begin p0_req = 1'b0; p0_lock = 1'b0; end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // Memory model: answers delay cycles after grant; delay 0 never answers.
  initial begin
    mem_ready = 1'b0;
    mem_response_data = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (force_ready) begin
        mem_ready = 1'b1;
        mem_response_data = 32'hDEAD_BEEF;
      end else if (mem_request) begin
        resp_cnt++;
        if (mem_delay > 0 && resp_cnt == mem_delay) begin
          mem_ready = 1'b1;
          if (mem_write_enable) mem_model[mem_address] = mem_write_data;
          else mem_response_data = mem_model.exists(mem_address) ?
                                   mem_model[mem_address] : mem_default(mem_address);
        end
      end else begin
        resp_cnt = 0;
      end
    end
  end

  // Monitor: pops grant expectations on mem_request rise, completion expectations on pulses.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      mon_prev_req = 1'b0;
    end else begin
      if (mem_request && !mon_prev_req) begin
        if (grant_q.size() == 0) begin
          chk("unexpected_grant", 32'(mem_request), 32'd0);
        end else begin
          mon_g = grant_q.pop_front();
          chk("grant_owner", 32'(owner), 32'(mon_g.port));
          chk("grant_addr", mem_address, mon_g.addr);
          chk("grant_we", 32'(mem_write_enable), 32'(mon_g.we));
          chk("grant_wdata", mem_write_data, mon_g.wdata);
          chk("grant_busy", 32'(busy), 32'd1);
          if (mon_g.gap >= 0) chk("grant_gap", cyc - last_done_cyc, mon_g.gap);
          grant_cyc = cyc;
          cap_addr  = mem_address;
          cap_wdata = mem_write_data;
        end
      end else if (mem_request) begin
        chk("mem_addr_stable", mem_address, cap_addr);
        chk("mem_wdata_stable", mem_write_data, cap_wdata);
      end
      if (p0_ready | p0_err | p1_ready | p1_err) begin
        chk("single_port_pulse", 32'((p0_ready | p0_err) & (p1_ready | p1_err)), 32'd0);
        if (done_q.size() == 0) begin
          chk("unexpected_completion", 32'({p0_ready, p0_err, p1_ready, p1_err}), 32'd0);
        end else begin
          mon_d   = done_q.pop_front();
          mon_is1 = p1_ready | p1_err;
          chk("done_port", 32'(mon_is1), 32'(mon_d.port));
          chk("done_err", 32'(mon_is1 ? p1_err : p0_err), 32'(mon_d.err));
          chk("done_ready", 32'(mon_is1 ? p1_ready : p0_ready), 32'(!mon_d.err));
          chk("done_rdata", mon_is1 ? p1_rdata : p0_rdata, mon_d.rdata);
          chk("done_latency", cyc - grant_cyc, mon_d.lat);
          chk("done_idle", 32'({mem_request, busy}), 32'd0);
        end
        last_done_cyc = cyc;
      end
      mon_prev_req = mem_request;
    end
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0802, 32'h0,         3, 32'hAAAA_AAAA, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678, 2, 32'h0,         1'b0};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         1, 32'h1234_5678, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0104, 32'hCAFE_F00D, 1, 32'h0,         1'b0};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,         4, 32'hCAFE_F00D, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_0200, 32'h0,         0, 32'h0,         1'b1};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         1, 32'h1234_5678, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 32'h0000_0300, 32'h0,         8, 32'h5A5A_595A, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 32'h0000_0304, 32'h0,         7, 32'h5A5A_595E, 1'b0};
    mem_model[32'h0000_0802] = 32'hAAAA_AAAA;
    last_rd[0] = '0;
    last_rd[1] = '0;

    reset = 1'b0;
    p0_req = 0; p0_we = 0; p0_lock = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_lock = 0; p1_addr = '0; p1_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_request", 32'(mem_request), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_mem_we", 32'(mem_write_enable), 32'd0);
    chk("rst_mem_addr", mem_address, 32'd0);
    chk("rst_mem_wdata", mem_write_data, 32'd0);
    chk("rst_p0_rdata", p0_rdata, 32'd0);
    chk("rst_p1_rdata", p1_rdata, 32'd0);
    chk("rst_pulses", 32'({p0_ready, p0_err, p1_ready, p1_err}), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      mem_delay = vecs[i].delay;
      expect_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
                 vecs[i].err, vecs[i].err ? int'(TO) : vecs[i].delay, -1);
      drive(vecs[i].port, vecs[i].we, 1'b0, vecs[i].addr, vecs[i].wdata);
      release_port(vecs[i].port);
      @(negedge clk);
      if (i == 0) chk("p0_rdata_untouched", p0_rdata, 32'd0);
    end

    // Fresh reset so the round-robin pointer favours port 0 again.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(negedge clk);

    // Both ports request together and keep req held: grants alternate 0,1,0,1.
    mem_delay = 1;
    expect_txn(1'b0, 1'b0, 32'h10, 32'h0, 32'h5A5A_5A4A, 1'b0, 1, -1);
    expect_txn(1'b1, 1'b0, 32'h14, 32'h0, 32'h5A5A_5A4E, 1'b0, 1, 1);
    expect_txn(1'b0, 1'b0, 32'h20, 32'h0, 32'h5A5A_5A7A, 1'b0, 1, 1);
    expect_txn(1'b1, 1'b0, 32'h24, 32'h0, 32'h5A5A_5A7E, 1'b0, 1, 1);
    fork
      begin
        drive(1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h20, 32'h0);
        release_port(1'b0);
      end
      begin
        drive(1'b1, 1'b0, 1'b0, 32'h14, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h24, 32'h0);
        release_port(1'b1);
      end
    join
    @(negedge clk);

    // Locked writeback+fill on port 1 must finish before port 0 is served.
    expect_txn(1'b1, 1'b1, 32'h0000_0832, 32'hBEEF_DEAD, 32'h0, 1'b0, 1, -1);
    expect_txn(1'b1, 1'b0, 32'hFFFF_F832, 32'h0, 32'hA5A5_A268, 1'b0, 1, 2);
    expect_txn(1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h5A5A_5A1A, 1'b0, 1, 1);
    fork
      begin
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0832, 32'hBEEF_DEAD);
        drive(1'b1, 1'b0, 1'b0, 32'hFFFF_F832, 32'h0);
        release_port(1'b1);
      end
      begin
        repeat (2) @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0);
        release_port(1'b0);
      end
    join
    @(negedge clk);

    // Reset while busy: everything clears at once and no completion pulse follows.
    mem_delay = 0;
    grant_q.push_back('{1'b1, 1'b0, 32'h0000_0500, 32'h0, -1});
    p1_we = 1'b0; p1_lock = 1'b0; p1_addr = 32'h0000_0500; p1_wdata = 32'h0; p1_req = 1'b1;
    for (int i = 0; i < 20 && !mem_request; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("arst_mem_request", 32'(mem_request), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_owner", 32'(owner), 32'd0);
    chk("arst_mem_addr", mem_address, 32'd0);
    chk("arst_p0_rdata", p0_rdata, 32'd0);
    chk("arst_p1_rdata", p1_rdata, 32'd0);
    p1_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    force_ready = 1'b1;
    repeat (2) @(negedge clk);
    force_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_ready_busy", 32'({busy, mem_request}), 32'd0);
    chk("idle_ready_p1_rdata", p1_rdata, 32'd0);
    chk("idle_ready_pulses", 32'({p0_ready, p0_err, p1_ready, p1_err}), 32'd0);

    chk("grant_q_drained", 32'(grant_q.size()), 32'd0);
    chk("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
